sccb_cfg_sequencer: RTL

Walks a camera register-init table and drives the bit-banged SCCB/I2C master's byte-level control pins (start, stop, wr_data). Each table entry becomes one 3-byte write: device address, register, value. The block sits between the init ROM and the SCCB master in the camera interface. Beyond writes, it supports a power-up wait, inline millisecond delays, an end marker, and NACK accounting.

---
 rtl/sccb_cfg_sequencer_if.sv | 28 ++
 rtl/sccb_cfg_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer_if.sv
// Bus between the camera init sequencer, its init ROM and the byte-level SCCB master.
// The master modport is the sequencer's view; the slave modport is the ROM/master side.
interface sccb_cfg_sequencer_if #(
  parameter int ROM_AW = 8
);
  logic              cfg_start;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              m_start;
  logic              m_stop;
  logic [7:0]        m_wr_data;
  logic [1:0]        m_ack;
  logic [3:0]        m_state;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_error;
  logic [7:0]        err_count;

  modport master (
    input  cfg_start, rom_data, m_ack, m_state,
    output rom_addr, m_start, m_stop, m_wr_data, cfg_busy, cfg_done, cfg_error, err_count
  );

  modport slave (
    output cfg_start, rom_data, m_ack, m_state,
    input  rom_addr, m_start, m_stop, m_wr_data, cfg_busy, cfg_done, cfg_error, err_count
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Walks a camera register-init table and issues one 3-byte SCCB write per entry.
// Optional macro SCCB_CFG_RETRY_EN: re-send a NACKed entry up to MAX_RETRY times.
module sccb_cfg_sequencer #(
  parameter int          CLK_HZ        = 100_000_000,
  parameter logic [7:0]  DEV_ADDR      = 8'h42,
  parameter int          ROM_AW        = 8,
  parameter int          INIT_DELAY_MS = 10,
  parameter logic [15:0] END_WORD      = 16'hFFFF,
  parameter logic [7:0]  DELAY_REG     = 8'hFE,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sccb_cfg_sequencer_if.master bus
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef SCCB_CFG_RETRY_EN
  localparam int RETRY_LIM = MAX_RETRY;
`else
  localparam int RETRY_LIM = 0 * MAX_RETRY;  // retries disabled
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_LATCH, S_DECODE, S_DELAY,
    S_TX_DEV, S_TX_REG, S_TX_VAL, S_TX_END, S_NEXT, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [TW-1:0]     tick_cnt;
  logic [15:0]       ms_cnt, ms_target;
  logic [15:0]       entry;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        m_wr_data, err_count, retry_cnt;
  logic              m_start, m_stop, cfg_busy, cfg_done, cfg_error;
  logic              started, val_acked, nack;
  logic              tick, ms_done, last, retry, ack_tick, m_idle;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign ms_target = (state == S_PWR) ? 16'(INIT_DELAY_MS) : {8'h00, entry[7:0]};
  assign ms_done   = (ms_cnt >= ms_target);
  assign last      = &rom_addr;
  assign retry     = nack && (retry_cnt < 8'(RETRY_LIM));
  assign ack_tick  = bus.m_ack[1];
  assign m_idle    = (bus.m_state == 4'd0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (bus.cfg_start) nxt = S_PWR;
      S_PWR:    if (ms_done) nxt = S_FETCH;
      S_FETCH:  nxt = S_LATCH;
      S_LATCH:  nxt = S_DECODE;
      S_DECODE: if (entry == END_WORD)          nxt = S_DONE;
                else if (entry[15:8] == DELAY_REG) nxt = S_DELAY;
                else                            nxt = S_TX_DEV;
      S_DELAY:  if (ms_done) nxt = last ? S_DONE : S_FETCH;
      S_TX_DEV: if (started && !m_idle) nxt = S_TX_REG;
      S_TX_REG: if (ack_tick) nxt = S_TX_VAL;
      S_TX_VAL: if (ack_tick) nxt = S_TX_END;
      S_TX_END: if (val_acked && m_idle) nxt = S_NEXT;
      S_NEXT:   if (retry) nxt = S_TX_DEV;
                else       nxt = last ? S_DONE : S_FETCH;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Millisecond timer; cleared outside the waiting states so every wait restarts fresh
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state == S_PWR || state == S_DELAY) begin
      if (tick) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + 16'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end else begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr  <= '0;
      entry     <= '0;
      m_wr_data <= '0;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      err_count <= '0;
      retry_cnt <= '0;
      started   <= 1'b0;
      val_acked <= 1'b0;
      nack      <= 1'b0;
    end else begin
      m_start  <= 1'b0;
      cfg_done <= 1'b0;
      case (state)
        S_IDLE: if (bus.cfg_start) begin
          rom_addr  <= '0;
          err_count <= '0;
          cfg_error <= 1'b0;
          cfg_busy  <= 1'b1;
          nack      <= 1'b0;
          retry_cnt <= '0;
        end
        S_LATCH: entry <= bus.rom_data;
        S_DELAY: if (ms_done && !last) rom_addr <= rom_addr + ROM_AW'(1);
        S_TX_DEV: begin
          val_acked <= 1'b0;
          if (!started) begin
            m_wr_data <= DEV_ADDR;
            if (m_idle) begin
              m_start <= 1'b1;
              started <= 1'b1;
            end
          end else if (!m_idle) begin
            // master holds byte 0; preload the register byte before its ack tick
            m_wr_data <= entry[15:8];
            started   <= 1'b0;
          end
        end
        S_TX_REG: if (ack_tick) begin
          if (!bus.m_ack[0]) nack <= 1'b1;
          m_wr_data <= entry[7:0];
        end
        S_TX_VAL: if (ack_tick) begin
          if (!bus.m_ack[0]) nack <= 1'b1;
          m_stop <= 1'b1;
        end
        S_TX_END: begin
          if (ack_tick && !val_acked) begin
            val_acked <= 1'b1;
            if (!bus.m_ack[0]) nack <= 1'b1;
          end
          if (val_acked && m_idle) m_stop <= 1'b0;
        end
        S_NEXT: begin
          nack <= 1'b0;
          if (retry) begin
            retry_cnt <= retry_cnt + 8'd1;
          end else begin
            retry_cnt <= '0;
            if (nack) begin
              cfg_error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (!last) rom_addr <= rom_addr + ROM_AW'(1);
          end
        end
        S_DONE: begin
          cfg_done <= 1'b1;
          cfg_busy <= 1'b0;
        end
        default: ;
      endcase
    end

  assign bus.rom_addr  = rom_addr;
  assign bus.m_start   = m_start;
  assign bus.m_stop    = m_stop;
  assign bus.m_wr_data = m_wr_data;
  assign bus.cfg_busy  = cfg_busy;
  assign bus.cfg_done  = cfg_done;
  assign bus.cfg_error = cfg_error;
  assign bus.err_count = err_count;

endmodule
